// File: rtl/ssb_uart_pkg.sv
// Shared constants for the system-bus UART transmitter:
// register offsets, STATUS/CTRL bit positions and the TX FSM state type.
package ssb_uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LVL   = 8;

  localparam int CTRL_PAR = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

endpackage

// File: rtl/ssb_uart_tx_if.sv
// System-bus device port: req/we/be/addr/wdata from the host,
// rvalid/rdata back one cycle later. No grant; always ready.
interface ssb_uart_tx_if;

  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output rvalid_o, rdata_o
  );

endinterface

// File: rtl/ssb_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter. Ports: clk, rst_n, push, pop,
// wdata/rdata (8b), full, empty, level. A push while full succeeds if popped.
module ssb_uart_tx_fifo #(
  parameter int Depth = 8,
  localparam int Aw = $clog2(Depth)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [Aw:0] level
);

  logic [7:0]  mem [Depth];
  logic [Aw:0] wptr;
  logic [Aw:0] rptr;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[Aw] != rptr[Aw]) &&
                 (wptr[Aw-1:0] == rptr[Aw-1:0]);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[Aw-1:0]];

  assign rd_en = pop & ~empty;
  // the slot being read this cycle is free for the write
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[Aw-1:0]] <= wdata;
  end

endmodule

// File: rtl/ssb_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the system bus (1-cycle rvalid).
// Ports: clk_i, rst_ni, bus (slave), tx_o, tx_empty_o. Macro UART_TX_PARITY_EN.
module ssb_uart_tx
  import ssb_uart_pkg::*;
#(
  parameter int          FifoDepth   = 8,
  parameter logic [15:0] ClkDivReset = 16'd867
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  ssb_uart_tx_if.slave bus,
  output logic         tx_o,
  output logic         tx_empty_o
);

  localparam int Lw = $clog2(FifoDepth) + 1;

  logic [1:0]     off;
  logic           wr;
  logic           rd;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_rdata;
  logic [Lw-1:0]  level;
  logic           ovf_q;
  logic           ovf_set;
  logic           ovf_clr;
  logic [15:0]    clkdiv_q;
  logic           par_q;
  logic           rvalid_q;
  logic [31:0]    rdata_q;
  logic [31:0]    rdata_d;
  logic [31:0]    status;
  logic [31:0]    ctrl;
  uart_tx_state_e state_q;
  uart_tx_state_e state_d;
  logic [15:0]    cnt_q;
  logic [15:0]    cnt_d;
  logic [2:0]     idx_q;
  logic [2:0]     idx_d;
  logic [7:0]     data_q;
  logic [7:0]     data_d;
  logic           tx_q;
  logic           tx_d;
  logic           empty_q;
  logic           bit_end;
  logic           unused;

  assign off = bus.addr_i[3:2];
  assign wr  = bus.req_i & bus.we_i;
  assign rd  = bus.req_i & ~bus.we_i;

  assign push = wr && off == REG_TXDATA && bus.be_i[0];
  assign ovf_clr = wr && off == REG_STATUS &&
                   bus.be_i[0] && bus.wdata_i[ST_OVF];
  // a pop in the same cycle makes room, so no overflow
  assign ovf_set = push & fifo_full & ~pop;

  ssb_uart_tx_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (pop),
    .wdata (bus.wdata_i[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    status = '0;
    status[ST_FULL]   = fifo_full;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_BUSY]   = state_q != IDLE;
    status[ST_OVF]    = ovf_q;
    status[ST_LVL+:8] = 8'(level);
    ctrl = '0;
    ctrl[15:0]     = clkdiv_q;
    ctrl[CTRL_PAR] = par_q;
    rdata_d = '0;
    if (rd) begin
      case (off)
        REG_STATUS: rdata_d = status;
        REG_CTRL:   rdata_d = ctrl;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      clkdiv_q <= ClkDivReset;
    end else begin
      rvalid_q <= bus.req_i;
      rdata_q  <= rdata_d;
      ovf_q    <= (ovf_q & ~ovf_clr) | ovf_set;
      if (wr && off == REG_CTRL) begin
        if (bus.be_i[0]) clkdiv_q[7:0]  <= bus.wdata_i[7:0];
        if (bus.be_i[1]) clkdiv_q[15:8] <= bus.wdata_i[15:8];
      end
    end
  end

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_en_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      par_en_q <= par_en_d;
      if (wr && off == REG_CTRL && bus.be_i[2])
        par_q <= bus.wdata_i[CTRL_PAR];
    end
  end

  assign unused = ^{bus.addr_i[31:4], bus.addr_i[1:0],
                    bus.be_i[3], bus.wdata_i[31:17]};
`else
  assign par_q  = 1'b0;
  assign unused = ^{bus.addr_i[31:4], bus.addr_i[1:0],
                    bus.be_i[3:2], bus.wdata_i[31:16]};
`endif

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_rdata;
          cnt_d   = clkdiv_q;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_en_d = par_q;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          cnt_d   = clkdiv_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = clkdiv_q;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = clkdiv_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = clkdiv_q;
          // chain the next frame with no idle gap
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_rdata;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_en_d = par_q;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // line level of the upcoming cycle, registered below
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^data_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      empty_q <= fifo_empty & (state_q == IDLE);
    end
  end

  assign tx_o       = tx_q;
  assign tx_empty_o = empty_q;

endmodule

// File: tb/tb_ssb_uart_tx.sv
// Self-checking bench for ssb_uart_tx: register vector table plus
// directed frame, overflow, mid-frame reset and parity sequences.
module tb_ssb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit ParOn = 1'b1;
`else
  localparam bit ParOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic tx_empty;
  logic cap = 1'b0;
  logic capq[$];
  int   checks = 0;
  int   errors = 0;

  ssb_uart_tx_if bus ();

  ssb_uart_tx dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .tx_o       (tx),
    .tx_empty_o (tx_empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cap) capq.push_back(tx);

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    @(negedge clk);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.be_i    = be;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    chk("rvalid", {31'b0, bus.rvalid_o}, 32'd1);
    rdata = bus.rdata_o;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be,
                    input logic [31:0] data);
    logic [31:0] r;
    xfer(1'b1, be, addr, data, r);
    chk("wr_rdata", r, 32'd0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp,
                    input string name);
    logic [31:0] r;
    xfer(1'b0, 4'hF, addr, 32'd0, r);
    chk(name, r, exp);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d,
                                             input bit par);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par) f[9] = ^d;
    return f;
  endfunction

  // call right after the accepting write returns
  task automatic check_frame(input logic [10:0] f, input int nb,
                             input int per, input string tag);
    int bad;
    for (int i = 0; i < nb; i++) begin
      bad = 0;
      for (int c = 0; c < per; c++) begin
        @(posedge clk);
        #1;
        if (tx !== f[i]) bad++;
        if (i == 0 && c == 0)
          chk({tag, "_busy_empty"}, {31'b0, tx_empty}, 32'd0);
      end
      chk($sformatf("%s_bit%0d_badcycles", tag, i), bad, 0);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk({tag, "_empty_after"}, {31'b0, tx_empty}, 32'd1);
    chk({tag, "_idle_high"}, {31'b0, tx}, 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int n;
    int last;
    int p;
    int zeros;
    logic [7:0] b;
    logic ok;

    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.be_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;

    tv.push_back('{1'b0, 4'hF, 32'h4, 32'h0, 32'h2, "status_rst"});
    tv.push_back('{1'b0, 4'hF, 32'h8, 32'h0, 32'h363, "ctrl_rst"});
    tv.push_back('{1'b0, 4'hF, 32'hC, 32'h0, 32'h0, "rd_off_c"});
    tv.push_back('{1'b0, 4'hF, 32'h0, 32'h0, 32'h0, "rd_txdata"});
    tv.push_back('{1'b1, 4'hE, 32'h0, 32'hAA, 32'h0, "wr_be_no_b0"});
    tv.push_back('{1'b0, 4'hF, 32'h4, 32'h0, 32'h2, "level_zero"});
    tv.push_back('{1'b0, 4'hF, 32'h104, 32'h0, 32'h2, "addr_alias"});
    tv.push_back('{1'b1, 4'h3, 32'h8, 32'h3, 32'h0, "wr_ctrl3"});
    tv.push_back('{1'b0, 4'hF, 32'h8, 32'h0, 32'h3, "rd_ctrl3"});
    tv.push_back('{1'b1, 4'h2, 32'h8, 32'h500, 32'h0, "wr_ctrl_b1"});
    tv.push_back('{1'b0, 4'hF, 32'h8, 32'h0, 32'h503, "rd_ctrl_b1"});
    tv.push_back('{1'b1, 4'hF, 32'h8, 32'hFFFE_0003, 32'h0, "wr_ctrl_all"});
    tv.push_back('{1'b1, 4'hF, 32'hC, 32'hFFFF_FFFF, 32'h0, "wr_off_c"});
    tv.push_back('{1'b0, 4'hF, 32'h8, 32'h0, 32'h3, "rd_ctrl_hi0"});
    tv.push_back('{1'b0, 4'hF, 32'hC, 32'h0, 32'h0, "rd_off_c2"});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_tx_empty", {31'b0, tx_empty}, 32'd1);
    chk("rst_rvalid", {31'b0, bus.rvalid_o}, 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);

    foreach (tv[i]) begin
      xfer(tv[i].we, tv[i].be, tv[i].addr, tv[i].wdata, r);
      chk(tv[i].name, r, tv[i].exp);
    end

    @(posedge clk);
    #1;
    chk("rvalid_idle", {31'b0, bus.rvalid_o}, 32'd0);
    chk("rdata_idle", bus.rdata_o, 32'd0);

    // single 0x55 frame, CLKDIV=3 from the table
    wr(32'h0, 4'h1, 32'h55);
    check_frame(frame_bits(8'h55, 1'b0), 10, 4, "f55");

    // fill and overflow
    wr(32'h8, 4'h3, 32'd1000);
    for (int k = 0; k < 10; k++) wr(32'h0, 4'h1, k);
    rd(32'h4, 32'h0000_080D, "status_full_ovf");

    cap = 1'b1;
    wr(32'h8, 4'h3, 32'd0);
    n = 0;
    while (!tx_empty && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_time", {31'b0, n < 3000}, 32'd1);
    cap = 1'b0;

    last = -1;
    foreach (capq[i]) if (capq[i] == 1'b0) last = i;
    chk("capture_len", {31'b0, last >= 88}, 32'd1);
    if (last >= 88) begin
      for (int k = 0; k < 9; k++) begin
        p  = last - 8 - 10 * (8 - k);
        ok = (capq[p] == 1'b0) && (capq[p+9] == 1'b1);
        for (int i = 0; i < 8; i++) b[i] = capq[p+1+i];
        chk($sformatf("drain_byte%0d", k), {23'b0, ok, b},
            {23'b0, 1'b1, 8'(k)});
      end
    end

    rd(32'h4, 32'h0000_000A, "status_ovf_sticky");
    wr(32'h4, 4'h1, 32'h8);
    rd(32'h4, 32'h0000_0002, "status_ovf_clr");

    // reset during data bit 3 of 0xA5, second byte queued
    wr(32'h8, 4'h3, 32'd3);
    wr(32'h0, 4'h1, 32'hA5);
    wr(32'h0, 4'h1, 32'h3C);
    repeat (17) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_bit3", {31'b0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'b0, tx}, 32'd1);
    chk("async_rst_empty", {31'b0, tx_empty}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(32'h4, 32'h0000_0002, "post_rst_status");
    rd(32'h8, 32'h0000_0363, "post_rst_ctrl");
    zeros = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) zeros++;
    end
    chk("no_residual_frame", zeros, 0);

    // parity control; frame length depends on the build
    wr(32'h8, 4'h7, 32'h0001_0003);
    rd(32'h8, ParOn ? 32'h0001_0003 : 32'h3, "ctrl_par");
    wr(32'h0, 4'h1, 32'h07);
    check_frame(frame_bits(8'h07, ParOn), ParOn ? 11 : 10, 4, "f07");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
